// File: rtl/mem_read_pipe.sv
// mem_read_pipe: parametrised single-write / single-read synchronous memory.
// One write port, one read port with a read-valid handshake, selectable
// read latency (0, 1 or 2 cycles), out-of-range address detection and a
// selectable read-during-write policy. Storage is never reset.
module mem_read_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LAT    = 1,
  parameter int unsigned BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_ren,
  input  logic [31:0]      io_raddr,
  input  logic             io_wen,
  input  logic [31:0]      io_waddr,
  input  logic [WIDTH-1:0] io_wdata,
  output logic             io_rvalid,
  output logic [WIDTH-1:0] io_rdata,
  output logic             io_rerr
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Word storage; contents survive reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Address decode. Any set bit above the index field makes the address
  // illegal; addresses are never folded back into the array.
  logic          rd_oob;
  logic          wr_oob;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_fire;
  logic          rd_hit;
  logic [WIDTH-1:0] rd_word;

  assign rd_oob  = |io_raddr[31:AW];
  assign wr_oob  = |io_waddr[31:AW];
  assign rd_idx  = io_raddr[AW-1:0];
  assign wr_idx  = io_waddr[AW-1:0];

  // A write only lands when out of reset and the address is legal.
  assign wr_fire = io_wen & reset & ~wr_oob;

  // Same-cycle write to the word being read: forward the new data only
  // when bypass is selected, otherwise the array supplies the old value.
  assign rd_hit  = (BYPASS != 0) && wr_fire && !rd_oob && (io_waddr == io_raddr);

  // Read result for the request presented this cycle.
  always_comb begin
    rd_word = '0;
    if (!rd_oob) begin
      rd_word = rd_hit ? io_wdata : mem_q[rd_idx];
    end
  end

`ifndef SYNTHESIS
  // Simulation-only scramble of the array so that reads of never-written
  // words do not silently look like zero.
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] = WIDTH'({$urandom, $urandom});
    end
  end
`endif

  // Write port: plain clocked array write so the storage maps onto RAM.
  always @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_idx] <= io_wdata;
    end
  end

  generate
    if (LAT == 0) begin : g_lat0
      // Purely combinational read path; nothing here sees reset.
      always_comb begin
        io_rvalid = io_ren;
        io_rerr   = io_ren & rd_oob;
        io_rdata  = io_ren ? rd_word : '0;
      end
    end else begin : g_pipe
      logic             s1_valid_q, s1_valid_d;
      logic             s1_err_q,   s1_err_d;
      logic [WIDTH-1:0] s1_data_q,  s1_data_d;

      // First stage next state: capture the request at its own edge so a
      // later write to the same word cannot change an in-flight result.
      always_comb begin
        s1_valid_d = io_ren;
        s1_err_d   = io_ren & rd_oob;
        s1_data_d  = io_ren ? rd_word : s1_data_q;
      end

      // First stage registers, cleared immediately by reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_valid_q <= 1'b0;
          s1_err_q   <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_err_q   <= s1_err_d;
          s1_data_q  <= s1_data_d;
        end
      end

      if (LAT == 1) begin : g_lat1
        assign io_rvalid = s1_valid_q;
        assign io_rerr   = s1_err_q;
        assign io_rdata  = s1_data_q;
      end else begin : g_lat2
        logic             s2_valid_q, s2_valid_d;
        logic             s2_err_q,   s2_err_d;
        logic [WIDTH-1:0] s2_data_q,  s2_data_d;

        // Second stage next state: advance a valid result, otherwise keep
        // the last data and drop valid/err.
        always_comb begin
          s2_valid_d = s1_valid_q;
          s2_err_d   = s1_valid_q & s1_err_q;
          s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        // Output register stage, cleared immediately by reset.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_data_q  <= '0;
          end else begin
            s2_valid_q <= s2_valid_d;
            s2_err_q   <= s2_err_d;
            s2_data_q  <= s2_data_d;
          end
        end

        assign io_rvalid = s2_valid_q;
        assign io_rerr   = s2_err_q;
        assign io_rdata  = s2_data_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_mem_read_pipe.sv
// Directed bench for mem_read_pipe. Four instances share one stimulus:
// LAT=1/BYPASS=1, LAT=1/BYPASS=0, LAT=2/BYPASS=1 and LAT=0/BYPASS=1.
module tb_mem_read_pipe;

  logic        clk;
  logic        reset;
  logic        io_ren;
  logic [31:0] io_raddr;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;

  logic        a_valid, b_valid, c_valid, z_valid;
  logic [31:0] a_data,  b_data,  c_data,  z_data;
  logic        a_err,   b_err,   c_err,   z_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_read_pipe #(.WIDTH(32), .DEPTH(8), .LAT(1), .BYPASS(1)) u_l1b1 (
    .clk(clk), .reset(reset), .io_ren(io_ren), .io_raddr(io_raddr),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_rvalid(a_valid), .io_rdata(a_data), .io_rerr(a_err));

  mem_read_pipe #(.WIDTH(32), .DEPTH(8), .LAT(1), .BYPASS(0)) u_l1b0 (
    .clk(clk), .reset(reset), .io_ren(io_ren), .io_raddr(io_raddr),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_rvalid(b_valid), .io_rdata(b_data), .io_rerr(b_err));

  mem_read_pipe #(.WIDTH(32), .DEPTH(8), .LAT(2), .BYPASS(1)) u_l2 (
    .clk(clk), .reset(reset), .io_ren(io_ren), .io_raddr(io_raddr),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_rvalid(c_valid), .io_rdata(c_data), .io_rerr(c_err));

  mem_read_pipe #(.WIDTH(32), .DEPTH(8), .LAT(0), .BYPASS(1)) u_l0 (
    .clk(clk), .reset(reset), .io_ren(io_ren), .io_raddr(io_raddr),
    .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_rvalid(z_valid), .io_rdata(z_data), .io_rerr(z_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    io_ren = 1'b0; io_raddr = '0;
    io_wen = 1'b0; io_waddr = '0; io_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1 reset = 1'b0;
    #1;
    // Reset state of the pipelined instances
    check("rst_a_valid", a_valid, 0);
    check("rst_a_data",  a_data,  0);
    check("rst_a_err",   a_err,   0);
    check("rst_c_valid", c_valid, 0);
    check("rst_c_data",  c_data,  0);
    cycle();
    cycle();
    reset = 1'b1;

    // Preload mem[i] = 0x10 + i
    for (int i = 0; i < 8; i++) begin
      io_wen = 1'b1; io_waddr = i; io_wdata = 32'h10 + i;
      cycle();
    end
    idle();

    // LAT=2 back-to-back reads of 0..7; LAT=0 checked in the same cycle
    for (int i = 0; i < 10; i++) begin
      io_ren = (i < 8); io_raddr = (i < 8) ? i : 0;
      #1;
      if (i < 8) begin
        check($sformatf("l0_valid_%0d", i), z_valid, 1);
        check($sformatf("l0_data_%0d", i),  z_data,  32'h10 + i);
      end else begin
        check($sformatf("l0_idle_valid_%0d", i), z_valid, 0);
        check($sformatf("l0_idle_data_%0d", i),  z_data,  0);
      end
      cycle();
      if (i >= 1 && i <= 8) begin
        check($sformatf("l2_valid_%0d", i), c_valid, 1);
        check($sformatf("l2_data_%0d", i),  c_data,  32'h10 + i - 1);
      end else begin
        check($sformatf("l2_valid_%0d", i), c_valid, 0);
      end
    end
    idle();

    // Write then read next cycle, LAT=1
    io_wen = 1'b1; io_waddr = 3; io_wdata = 32'hDEADBEEF;
    cycle();
    idle();
    io_ren = 1'b1; io_raddr = 3;
    cycle();
    check("l1_rd3_valid", a_valid, 1);
    check("l1_rd3_data",  a_data,  32'hDEADBEEF);
    check("l1_rd3_err",   a_err,   0);
    idle();
    cycle();
    check("l1_idle_valid", a_valid, 0);
    check("l1_idle_hold",  a_data,  32'hDEADBEEF);

    // Read-during-write on addr 5
    io_wen = 1'b1; io_waddr = 5; io_wdata = 32'h12345678;
    cycle();
    io_wen = 1'b1; io_waddr = 5; io_wdata = 32'hAAAA5555;
    io_ren = 1'b1; io_raddr = 5;
    #1;
    check("l0_rdw_bypass", z_data, 32'hAAAA5555);
    cycle();
    check("rdw_bypass1", a_data, 32'hAAAA5555);
    check("rdw_bypass0", b_data, 32'h12345678);
    idle();
    io_ren = 1'b1; io_raddr = 5;
    cycle();
    check("rdw_after_b1", a_data, 32'hAAAA5555);
    check("rdw_after_b0", b_data, 32'hAAAA5555);
    idle();

    // Out-of-range read and write
    io_ren = 1'b1; io_raddr = 8;
    #1;
    check("l0_oob_err",  z_err,  1);
    check("l0_oob_data", z_data, 0);
    cycle();
    check("oob_valid", a_valid, 1);
    check("oob_err",   a_err,   1);
    check("oob_data",  a_data,  0);
    io_raddr = 32'h8000_0002;
    cycle();
    check("oob_hi_err",  a_err,  1);
    check("oob_hi_data", a_data, 0);
    idle();
    io_wen = 1'b1; io_waddr = 32'h108; io_wdata = 32'hFFFFFFFF;
    cycle();
    idle();
    io_ren = 1'b1; io_raddr = 0;
    cycle();
    check("oob_wr_mem0", a_data, 32'h10);
    check("oob_wr_err",  a_err,  0);
    idle();

    // In-flight result not altered by a later write (LAT=2)
    io_ren = 1'b1; io_raddr = 2;
    cycle();
    idle();
    io_wen = 1'b1; io_waddr = 2; io_wdata = 32'h99;
    cycle();
    check("inflight_valid", c_valid, 1);
    check("inflight_data",  c_data,  32'h12);
    idle();
    cycle();

    // Reset mid-flight on LAT=2
    io_ren = 1'b1; io_raddr = 4;
    cycle();
    cycle();
    check("pre_rst_valid", c_valid, 1);
    check("pre_rst_data",  c_data,  32'h14);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_c_valid", c_valid, 0);
    check("mid_rst_c_data",  c_data,  0);
    check("mid_rst_a_valid", a_valid, 0);
    check("mid_rst_a_data",  a_data,  0);
    idle();
    io_wen = 1'b1; io_waddr = 1; io_wdata = 32'hFFFF; io_ren = 1'b1; io_raddr = 4;
    cycle();
    cycle();
    check("in_rst_c_valid", c_valid, 0);
    idle();
    reset = 1'b1;
    cycle();
    check("post_rst_valid1", c_valid, 0);
    cycle();
    check("post_rst_valid2", c_valid, 0);
    io_ren = 1'b1; io_raddr = 1;
    cycle();
    idle();
    cycle();
    check("post_rst_rd1_valid", c_valid, 1);
    check("post_rst_rd1_data",  c_data,  32'h11);
    io_ren = 1'b1; io_raddr = 4;
    cycle();
    idle();
    cycle();
    check("post_rst_rd4_data", c_data, 32'h14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_read_pipe.md
Name: mem_read_pipe

Overview:
Parametrised single-write, single-read synchronous memory with selectable read latency and an explicit read handshake. Successor to the fixed 8x32 combinational-read memory: generalises width, depth and latency, and adds a write port, read-valid tracking, out-of-range detection and defined read-during-write behaviour. Used as the generic register-file/table primitive in the datapath.

Parameters:
WIDTH, 32, data word width in bits (1..64)
DEPTH, 8, number of words; power of two, 2..1024
LAT, 1, read latency in cycles; legal values 0, 1, 2
BYPASS, 1, read-during-write to same address: 1 returns new data, 0 returns old data

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
io_ren  input  1  read request, sampled each cycle
io_raddr  input  32  read word address
io_wen  input  1  write enable
io_waddr  input  32  write word address
io_wdata  input  WIDTH  write data
io_rvalid  output  1  read data valid, LAT cycles after io_ren
io_rdata  output  WIDTH  read data
io_rerr  output  1  qualifies io_rvalid: request address was out of range

Behaviour:
- AW = log2(DEPTH). An address is in range iff bits [31:AW] are all zero; no silent truncation/wrap.
- Storage: DEPTH x WIDTH array, not reset; simulation-only random init guarded by SYNTHESIS.
- Write: on a rising edge with io_wen=1, reset deasserted and io_waddr in range, mem[io_waddr] <= io_wdata. Out-of-range writes are dropped; no flag.
- Read result for a request: in range -> mem[raddr] (subject to bypass rule), io_rerr=0; out of range -> data 0, io_rerr=1.
- Read-during-write (io_ren & io_wen, same in-range address, same cycle): BYPASS=1 -> result is io_wdata; BYPASS=0 -> result is pre-write contents.
- LAT=0: io_rvalid = io_ren, io_rdata/io_rerr combinational from current inputs; when io_ren=0, io_rdata=0 and io_rerr=0. No registers besides storage; reset has no effect on outputs.
- LAT=1: request sampled at edge N; io_rvalid/io_rdata/io_rerr valid after edge N, i.e. during cycle N+1. When no request was sampled, io_rvalid=0, io_rerr=0, io_rdata holds last value.
- LAT=2: LAT=1 result passes through one further output register stage; valid during cycle N+2. Back-to-back requests every cycle are fully pipelined; each returns in order, one per cycle.
- Data for a read is captured at the request edge; a write to the same address in a later cycle never alters an in-flight result.
- Reset (LAT>=1): asynchronous assert clears every valid, rerr and rdata pipeline register to 0 immediately; in-flight reads are discarded, not replayed. Storage contents are retained across reset. Writes and reads are ignored while reset is low; first request accepted on the first rising edge with reset high.
- Reset values (LAT>=1): io_rvalid=0, io_rdata=0, io_rerr=0.

Test Plan:
- DEPTH=8, WIDTH=32, LAT=1: write 0xDEADBEEF to addr 3, then io_ren addr 3 next cycle -> io_rvalid=1, io_rdata=0xDEADBEEF, io_rerr=0 exactly one cycle later.
- LAT=2, back-to-back reads of addrs 0..7 preloaded with 0x10+i -> io_rvalid high 8 consecutive cycles starting 2 cycles after first request, data 0x10..0x17 in order.
- Same-cycle write 0xAAAA5555 and read to addr 5 (old 0x12345678): BYPASS=1 -> 0xAAAA5555; BYPASS=0 -> 0x12345678; next read -> 0xAAAA5555 in both.
- io_raddr=8 with DEPTH=8 -> io_rvalid=1, io_rerr=1, io_rdata=0; io_waddr=0x108 write -> mem[0] unchanged.
- LAT=2, issue read, assert reset low mid-flight (between edges) -> io_rvalid/io_rdata drop to 0 immediately, no valid after release; memory contents still readable afterwards.
- LAT=0: io_ren=1 addr 2 -> io_rdata equals mem[2] in same cycle, io_rvalid=1; io_ren=0 -> io_rdata=0, io_rvalid=0.
